// File: rtl/writeback_scoreboard.sv
// Writeback stage: merges ALU and load results into one registered regfile write per cycle
// and tracks in-flight writes per register for RAW hazard stalls.
module writeback_scoreboard #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned PEND_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_stall,
    input  logic [ADDR_W-1:0] src0_addr,
    input  logic [ADDR_W-1:0] src1_addr,
    output logic              src0_busy,
    output logic              src1_busy,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              reg_write_enable,
    output logic [ADDR_W-1:0] data_write_address,
    output logic [DATA_W-1:0] data_write,
    output logic              err_underflow
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PendMax = '1;

    logic [PEND_W-1:0] pending_q [NumRegs];
    logic [PEND_W-1:0] pending_d [NumRegs];

    logic              hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q, err_d;

    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              mem_accept;
    logic              issue_inc;

    assign mem_ready   = ~hold_valid_q;
    assign mem_accept  = mem_valid & mem_ready;
    assign issue_stall = (pending_q[issue_addr] == PendMax);
    assign issue_inc   = issue_valid & ~issue_stall;
    assign src0_busy   = (pending_q[src0_addr] != '0);
    assign src1_busy   = (pending_q[src1_addr] != '0);

    assign reg_write_enable   = we_q;
    assign data_write_address = waddr_q;
    assign data_write         = wdata_q;
    assign err_underflow      = err_q;

    // ALU always wins; a colliding load is parked and drained on the next ALU-free cycle.
    always_comb begin
        sel_valid   = 1'b0;
        sel_addr    = alu_addr;
        sel_data    = alu_data;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        if (alu_valid) begin
            sel_valid = 1'b1;
            if (mem_accept) begin
                hold_valid_d = 1'b1;
                hold_addr_d  = mem_addr;
                hold_data_d  = mem_data;
            end
        end else if (hold_valid_q) begin
            sel_valid    = 1'b1;
            sel_addr     = hold_addr_q;
            sel_data     = hold_data_q;
            hold_valid_d = 1'b0;
        end else if (mem_accept) begin
            sel_valid = 1'b1;
            sel_addr  = mem_addr;
            sel_data  = mem_data;
        end
    end

    // A commit retires one pending write; an issue to the same register cancels it out.
    always_comb begin
        err_d = err_q | (we_q & (pending_q[waddr_q] == '0));
        for (int i = 0; i < NumRegs; i++) begin
            logic inc, dec;
            inc = issue_inc & (issue_addr == ADDR_W'(i));
            dec = we_q & (waddr_q == ADDR_W'(i));
            pending_d[i] = pending_q[i];
            if (inc && !dec) begin
                pending_d[i] = pending_q[i] + PEND_W'(1);
            end else if (dec && !inc && (pending_q[i] != '0)) begin
                pending_d[i] = pending_q[i] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NumRegs; i++) begin
                pending_q[i] <= '0;
            end
        end else begin
            we_q         <= sel_valid;
            if (sel_valid) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            err_q        <= err_d;
            for (int i = 0; i < NumRegs; i++) begin
                pending_q[i] <= pending_d[i];
            end
        end
    end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Randomized bench for writeback_scoreboard against a queue-based reference model.
module tb_writeback_scoreboard;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic [2:0]  issue_addr;
    logic        issue_stall;
    logic [2:0]  src0_addr, src1_addr;
    logic        src0_busy, src1_busy;
    logic        alu_valid;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data;
    logic        reg_write_enable;
    logic [2:0]  data_write_address;
    logic [15:0] data_write;
    logic        err_underflow;

    writeback_scoreboard dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .issue_valid        (issue_valid),
        .issue_addr         (issue_addr),
        .issue_stall        (issue_stall),
        .src0_addr          (src0_addr),
        .src1_addr          (src1_addr),
        .src0_busy          (src0_busy),
        .src1_busy          (src1_busy),
        .alu_valid          (alu_valid),
        .alu_addr           (alu_addr),
        .alu_data           (alu_data),
        .mem_valid          (mem_valid),
        .mem_ready          (mem_ready),
        .mem_addr           (mem_addr),
        .mem_data           (mem_data),
        .reg_write_enable   (reg_write_enable),
        .data_write_address (data_write_address),
        .data_write         (data_write),
        .err_underflow      (err_underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    // Reference state: in-flight counts, parked loads and the last registered write.
    int  m_pend [8];
    wr_t m_hold [$];
    int  m_we, m_addr, m_data, m_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
        m_hold.delete();
        m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int  delta [8];
        bit  accepted, stalled, wrote;
        wr_t w, nw;
        accepted = mem_valid && (m_hold.size() == 0);
        stalled  = (m_pend[issue_addr] == 3);
        wrote    = 1'b0;
        w.addr = int'(mem_addr);
        w.data = int'(mem_data);
        nw = w;
        if (alu_valid) begin
            wrote = 1'b1;
            nw.addr = int'(alu_addr);
            nw.data = int'(alu_data);
            if (accepted) m_hold.push_back(w);
        end else if (m_hold.size() != 0) begin
            wrote = 1'b1;
            nw = m_hold.pop_front();
        end else if (accepted) begin
            wrote = 1'b1;
        end
        for (int i = 0; i < 8; i++) delta[i] = 0;
        if (issue_valid && !stalled) delta[issue_addr] += 1;
        if (m_we != 0) begin
            if (m_pend[m_addr] == 0) m_err = 1;
            delta[m_addr] -= 1;
        end
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = m_pend[i] + delta[i];
            if (m_pend[i] < 0) m_pend[i] = 0;
        end
        m_we = wrote;
        if (wrote) begin
            m_addr = nw.addr;
            m_data = nw.data;
        end
    endtask

    task automatic check_all();
        check_eq("mem_ready", mem_ready, (m_hold.size() == 0));
        check_eq("issue_stall", issue_stall, (m_pend[issue_addr] == 3));
        check_eq("src0_busy", src0_busy, (m_pend[src0_addr] != 0));
        check_eq("src1_busy", src1_busy, (m_pend[src1_addr] != 0));
        check_eq("we", reg_write_enable, m_we);
        check_eq("waddr", data_write_address, m_addr);
        check_eq("wdata", data_write, m_data);
        check_eq("err", err_underflow, m_err);
    endtask

    // Called just after a rising edge; inputs are already driven.
    task automatic step();
        @(negedge clock);
        check_all();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_addr = 0; src0_addr = 0; src1_addr = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_we", reg_write_enable, 0);
        check_eq("rst_waddr", data_write_address, 0);
        check_eq("rst_wdata", data_write, 0);
        check_eq("rst_ready", mem_ready, 1);
        check_eq("rst_err", err_underflow, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_eq("por_we", reg_write_enable, 0);
        check_eq("por_ready", mem_ready, 1);
        check_eq("por_busy", src0_busy, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Issue r3, ALU result two cycles later, busy until the cycle after commit.
        issue_valid = 1; issue_addr = 3; src0_addr = 3;
        step();
        issue_valid = 0;
        check_eq("t1_busy_T1", src0_busy, 1);
        step();
        alu_valid = 1; alu_addr = 3; alu_data = 16'h1234;
        step();
        alu_valid = 0;
        check_eq("t1_we", reg_write_enable, 1);
        check_eq("t1_addr", data_write_address, 3);
        check_eq("t1_data", data_write, 16'h1234);
        check_eq("t1_busy_T3", src0_busy, 1);
        step();
        check_eq("t1_busy_T4", src0_busy, 0);

        // ALU and load collide: load is parked and written a cycle later.
        issue_valid = 1; issue_addr = 1;
        step();
        issue_addr = 2;
        step();
        issue_valid = 0;
        alu_valid = 1; alu_addr = 1; alu_data = 16'hAAAA;
        mem_valid = 1; mem_addr = 2; mem_data = 16'h5555;
        step();
        alu_valid = 0; mem_valid = 0;
        check_eq("t2_ready", mem_ready, 0);
        check_eq("t2_first", data_write, 16'hAAAA);
        step();
        check_eq("t2_second", data_write, 16'h5555);
        check_eq("t2_addr", data_write_address, 2);

        // Saturate r5.
        issue_addr = 5; issue_valid = 1;
        repeat (4) step();
        check_eq("t4_stall", issue_stall, 1);
        issue_valid = 0;

        // Underflow on r6, then reset with a held load and live counters.
        alu_valid = 1; alu_addr = 6; alu_data = 16'h0606;
        mem_valid = 1; mem_addr = 4; mem_data = 16'h4444;
        step();
        alu_data = 16'h0707; mem_valid = 0;
        step();
        check_eq("t5_ready_hold", mem_ready, 0);
        alu_valid = 0;
        step();
        check_eq("t5_err", err_underflow, 1);
        alu_valid = 1; alu_addr = 0; alu_data = 16'h1111;
        mem_valid = 1; mem_addr = 7; mem_data = 16'h7777;
        step();
        do_reset();
        step();
        check_eq("t6_busy", src0_busy, 0);
        check_eq("t6_no_hold_write", reg_write_enable, 0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_addr  = 3'($urandom_range(0, 7));
            src0_addr   = 3'($urandom_range(0, 7));
            src1_addr   = 3'($urandom_range(0, 7));
            alu_valid   = ($urandom_range(0, 9) < 4);
            alu_addr    = 3'($urandom_range(0, 7));
            alu_data    = 16'($urandom);
            mem_valid   = ($urandom_range(0, 1) == 1);
            mem_addr    = 3'($urandom_range(0, 7));
            mem_data    = 16'($urandom);
            step();
            if ((cyc % 600) == 599) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
